// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB control unit with trap, bus-timeout and retire counting
module multicycle_ctrl_fsm #(
  parameter int ALUCTRL_W = 4,
  parameter int TIMEOUT = 15,
  parameter int TO_W = 4,
  parameter int RET_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [31:0]          instr_i,
  input  logic                 mem_ready_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic                 ir_we_o,
  output logic                 pc_we_o,
  output logic                 alu_src_o,
  output logic                 reg_write_o,
  output logic                 mem_to_reg_o,
  output logic [1:0]           shift_o,
  output logic [ALUCTRL_W-1:0] alu_ctrl_o,
  output logic                 branch_o,
  output logic                 jump_o,
  output logic                 trap_o,
  output logic                 bus_err_o,
  output logic [RET_W-1:0]     retired_o
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(4'b0010);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(4'b0110);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(4'b0000);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(4'b0001);
  localparam logic [ALUCTRL_W-1:0] ALU_IMM = ALUCTRL_W'(4'b1111);
  state_t state, nxt;
  logic [31:0] ir;
  logic [TO_W-1:0] cnt;
  logic is_ld, is_st, is_br, is_jmp;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic d_r, d_i, d_ld, d_st, d_jr, d_j, d_br, d_legal, d_src;
  logic [1:0] d_shift;
  logic [ALUCTRL_W-1:0] d_alu;
  logic mem_phase, wait_c, timeout, done, pc_set, unused_ir;
  assign opc = ir[6:0];
  assign f3 = ir[14:12];
  assign f7 = ir[31:25];
  assign unused_ir = ^{ir[24:15], ir[11:7]};
  assign d_r = opc == 7'h33;
  assign d_i = opc == 7'h13;
  assign d_ld = opc == 7'h03;
  assign d_st = opc == 7'h23;
  assign d_jr = opc == 7'h67;
  assign d_j = opc == 7'h6F;
  assign d_br = opc == 7'h63;
  assign d_legal = d_r | d_i | d_ld | d_st | d_jr | d_j | d_br;
  assign d_src = d_i | d_ld | d_st | d_jr;
  assign d_shift = d_i ? (f3 == 3'b001 ? 2'b11 : 2'b10) : 2'b00;
  assign d_alu = d_r ? (f7 != 7'h00 ? ALU_SUB : f3 == 3'b000 ? ALU_ADD : f3 == 3'b111 ? ALU_AND : ALU_OR)
               : d_i ? ALU_IMM : d_br ? ALU_SUB : ALU_ADD;
  // A wait cycle is one where a request is on the bus and memory has not answered.
  assign mem_phase = state == FETCH || state == MEM;
  assign wait_c = mem_phase && mem_req_o && !mem_ready_i;
  assign timeout = wait_c && cnt == TO_W'(TIMEOUT - 1);
  assign done = mem_phase && mem_req_o && mem_ready_i;
  assign pc_set = (state == DECODE && d_legal && d_br) || nxt == WB || (state == MEM && done && is_st);
  always_comb begin
    nxt = state;
    case (state)
      FETCH:   nxt = timeout ? TRAP : done ? DECODE : FETCH;
      DECODE:  nxt = d_legal ? EXEC : TRAP;
      EXEC:    nxt = (is_ld || is_st) ? MEM : is_br ? FETCH : WB;
      MEM:     nxt = timeout ? TRAP : done ? (is_ld ? WB : FETCH) : MEM;
      WB:      nxt = FETCH;
      default: nxt = TRAP;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= FETCH;
      ir <= '0;
      cnt <= '0;
      {is_ld, is_st, is_br, is_jmp} <= '0;
      {mem_req_o, mem_we_o, ir_we_o, pc_we_o, alu_src_o, reg_write_o, mem_to_reg_o} <= '0;
      {branch_o, jump_o, trap_o, bus_err_o} <= '0;
      shift_o <= '0;
      alu_ctrl_o <= '0;
      retired_o <= '0;
    end else begin
      state <= nxt;
      if (state == FETCH && done) ir <= instr_i;
      if (nxt != state && (nxt == FETCH || nxt == MEM)) cnt <= '0;
      else if (wait_c) cnt <= cnt + 1'b1;
      if (state == DECODE && d_legal) begin
        {is_ld, is_st, is_br, is_jmp} <= {d_ld, d_st, d_br, d_jr | d_j};
        alu_src_o <= d_src;
        mem_to_reg_o <= d_ld;
        shift_o <= d_shift;
        alu_ctrl_o <= d_alu;
      end
      mem_req_o <= nxt == FETCH || nxt == MEM;
      mem_we_o <= nxt == MEM && is_st;
      ir_we_o <= state == FETCH && done;
      pc_we_o <= pc_set;
      retired_o <= retired_o + RET_W'(pc_set);
      reg_write_o <= nxt == WB;
      jump_o <= nxt == WB && is_jmp;
      branch_o <= state == DECODE && d_legal && d_br;
      trap_o <= trap_o | (state == DECODE && !d_legal);
      bus_err_o <= bus_err_o | timeout;
    end
  end
endmodule
